param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_if.sv | 32 +++
 rtl/param_fifo.sv | 105 ++++++++++
 tb/tb_param_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// Handshake bundle for param_fifo: producer/consumer side is the master, the FIFO is the slave.
interface param_fifo_if #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              push;
    logic [DWIDTH-1:0] push_data;
    logic              full;
    logic              almost_full;
    logic              pop;
    logic [DWIDTH-1:0] pop_data;
    logic              pop_valid;
    logic              not_empty;
    logic              almost_empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, push_data, pop,
        input  full, almost_full, pop_data, pop_valid, not_empty,
               almost_empty, level, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop,
        output full, almost_full, pop_data, pop_valid, not_empty,
               almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with registered level, optional first-word-fall-through
// read port, programmable almost flags and sticky overflow/underflow indicators.
module param_fifo #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic         aclk,
    input  logic         areset,
    param_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              full_w;
    logic              not_empty_w;
    logic              push_acc;
    logic              pop_acc;

    // Flags decode from the registered level, so they trail the causing edge by one cycle.
    assign full_w      = (level_r == LVL_FULL);
    assign not_empty_w = (level_r != '0);
    assign push_acc    = bus.push && !full_w;
    assign pop_acc     = bus.pop && not_empty_w;

    assign bus.full         = full_w;
    assign bus.not_empty    = not_empty_w;
    assign bus.almost_full  = (int'(level_r) >= AFULL_LVL);
    assign bus.almost_empty = (int'(level_r) <= AEMPTY_LVL);
    assign bus.level        = level_r;
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

    // Storage is deliberately not reset; stale entries are unreachable once level is cleared.
    always_ff @(posedge aclk) begin
        if (push_acc) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_acc, pop_acc})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            if (bus.push && full_w) begin
                overflow_r <= 1'b1;
            end
            if (bus.pop && !not_empty_w) begin
                underflow_r <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while empty so no pre-reset data leaks out.
            assign bus.pop_data  = not_empty_w ? mem[rd_ptr] : '0;
            assign bus.pop_valid = not_empty_w;
        end else begin : g_std
            logic [DWIDTH-1:0] pop_data_p1;
            logic              vld_p1;

            always_ff @(posedge aclk) begin
                if (areset) begin
                    pop_data_p1 <= '0;
                    vld_p1      <= 1'b0;
                end else begin
                    vld_p1 <= pop_acc;
                    if (pop_acc) begin
                        pop_data_p1 <= mem[rd_ptr];
                    end
                end
            end

            assign bus.pop_data  = pop_data_p1;
            assign bus.pop_valid = vld_p1;
        end
    endgenerate
endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: DEPTH=4, DWIDTH=8, standard and FWFT instances share stimulus.
module tb_param_fifo;
    localparam int DW = 8;
    localparam int DP = 4;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    param_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) bus0 ();
    param_fifo_if #(.DWIDTH(DW), .DEPTH(DP)) bus1 ();

    assign bus1.push      = bus0.push;
    assign bus1.push_data = bus0.push_data;
    assign bus1.pop       = bus0.pop;

    param_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut_std (
        .aclk(aclk), .areset(areset), .bus(bus0.slave));
    param_fifo #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut_fwft (
        .aclk(aclk), .areset(areset), .bus(bus1.slave));

    typedef struct {
        logic       rst, push, pop;
        logic [7:0] din;
        logic [2:0] lvl;
        logic       full, af, ne, ae, pv;
        logic [7:0] pd;
        logic       ovf, udf;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rst, push, input logic [7:0] din, input logic pop,
                                input logic [2:0] lvl, input logic full, af, ne, ae, pv,
                                input logic [7:0] pd, input logic ovf, udf);
        vec_t v;
        v.rst = rst; v.push = push; v.din = din; v.pop = pop;
        v.lvl = lvl; v.full = full; v.af = af; v.ne = ne; v.ae = ae; v.pv = pv;
        v.pd = pd; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic step(input logic rst, push, input logic [7:0] din, input logic pop);
        @(negedge aclk);
        areset         = rst;
        bus0.push      = push;
        bus0.push_data = din;
        bus0.pop       = pop;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    logic [17:0] got_v, exp_v;

    initial begin
        areset = 1'b0; bus0.push = 1'b0; bus0.pop = 1'b0; bus0.push_data = '0;

        //           rst push din   pop  lvl full af ne ae pv pd    ovf udf
        vecs[0]  = mk(1, 1, 8'h99, 0,   0,  0,  0, 0, 1, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 1, 8'h11, 0,   1,  0,  0, 1, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(0, 1, 8'h22, 0,   2,  0,  0, 1, 0, 0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 1, 8'h33, 0,   3,  0,  1, 1, 0, 0, 8'h00, 0, 0);
        vecs[4]  = mk(0, 1, 8'h44, 0,   4,  1,  1, 1, 0, 0, 8'h00, 0, 0);
        vecs[5]  = mk(0, 1, 8'h55, 0,   4,  1,  1, 1, 0, 0, 8'h00, 1, 0);
        vecs[6]  = mk(0, 0, 8'h00, 1,   3,  0,  1, 1, 0, 1, 8'h11, 1, 0);
        vecs[7]  = mk(0, 0, 8'h00, 1,   2,  0,  0, 1, 0, 1, 8'h22, 1, 0);
        vecs[8]  = mk(0, 0, 8'h00, 1,   1,  0,  0, 1, 1, 1, 8'h33, 1, 0);
        vecs[9]  = mk(0, 0, 8'h00, 1,   0,  0,  0, 0, 1, 1, 8'h44, 1, 0);
        vecs[10] = mk(0, 0, 8'h00, 1,   0,  0,  0, 0, 1, 0, 8'h44, 1, 1);
        vecs[11] = mk(0, 0, 8'h00, 0,   0,  0,  0, 0, 1, 0, 8'h44, 1, 1);
        vecs[12] = mk(1, 0, 8'h00, 0,   0,  0,  0, 0, 1, 0, 8'h00, 0, 0);
        vecs[13] = mk(0, 1, 8'h61, 0,   1,  0,  0, 1, 1, 0, 8'h00, 0, 0);
        vecs[14] = mk(0, 1, 8'h62, 0,   2,  0,  0, 1, 0, 0, 8'h00, 0, 0);
        vecs[15] = mk(0, 1, 8'h63, 0,   3,  0,  1, 1, 0, 0, 8'h00, 0, 0);
        vecs[16] = mk(0, 1, 8'h64, 0,   4,  1,  1, 1, 0, 0, 8'h00, 0, 0);
        vecs[17] = mk(0, 1, 8'h66, 1,   3,  0,  1, 1, 0, 1, 8'h61, 1, 0);
        vecs[18] = mk(0, 0, 8'h00, 1,   2,  0,  0, 1, 0, 1, 8'h62, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 1,   1,  0,  0, 1, 1, 1, 8'h63, 1, 0);
        vecs[20] = mk(0, 0, 8'h00, 1,   0,  0,  0, 0, 1, 1, 8'h64, 1, 0);
        vecs[21] = mk(0, 0, 8'h00, 1,   0,  0,  0, 0, 1, 0, 8'h64, 1, 1);
        vecs[22] = mk(0, 1, 8'h71, 0,   1,  0,  0, 1, 1, 0, 8'h64, 1, 1);
        vecs[23] = mk(0, 1, 8'h72, 0,   2,  0,  0, 1, 0, 0, 8'h64, 1, 1);
        vecs[24] = mk(0, 1, 8'h73, 0,   3,  0,  1, 1, 0, 0, 8'h64, 1, 1);
        vecs[25] = mk(1, 1, 8'h99, 0,   0,  0,  0, 0, 1, 0, 8'h00, 0, 0);
        vecs[26] = mk(0, 1, 8'h77, 0,   1,  0,  0, 1, 1, 0, 8'h00, 0, 0);
        vecs[27] = mk(0, 0, 8'h00, 1,   0,  0,  0, 0, 1, 1, 8'h77, 0, 0);
        vecs[28] = mk(0, 0, 8'h00, 0,   0,  0,  0, 0, 1, 0, 8'h77, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].pop);
            got_v = {bus0.level, bus0.full, bus0.almost_full, bus0.not_empty, bus0.almost_empty,
                     bus0.pop_valid, bus0.pop_data, bus0.overflow, bus0.underflow};
            exp_v = {vecs[i].lvl, vecs[i].full, vecs[i].af, vecs[i].ne, vecs[i].ae,
                     vecs[i].pv, vecs[i].pd, vecs[i].ovf, vecs[i].udf};
            chk($sformatf("vec%0d", i), 32'(got_v), 32'(exp_v));
        end

        // First-word-fall-through: latency into empty, hold without pop, advance on pop.
        step(1, 0, 8'h00, 0);
        chk("fwft_rst_pv", 32'(bus1.pop_valid), 32'd0);
        chk("fwft_rst_pd", 32'(bus1.pop_data), 32'h00);
        step(0, 1, 8'hA5, 0);
        chk("fwft_lat_pv", 32'(bus1.pop_valid), 32'd1);
        chk("fwft_lat_pd", 32'(bus1.pop_data), 32'hA5);
        chk("std_nopop_pv", 32'(bus0.pop_valid), 32'd0);
        step(0, 1, 8'hB6, 0);
        chk("fwft_hold_pd", 32'(bus1.pop_data), 32'hA5);
        step(0, 0, 8'h00, 1);
        chk("fwft_adv_pd", 32'(bus1.pop_data), 32'hB6);
        chk("fwft_adv_pv", 32'(bus1.pop_valid), 32'd1);
        step(0, 0, 8'h00, 1);
        chk("fwft_empty_pv", 32'(bus1.pop_valid), 32'd0);
        chk("fwft_empty_pd", 32'(bus1.pop_data), 32'h00);

        // Simultaneous push+pop at level 2 across several pointer wraps.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'd1, 0);
        step(0, 1, 8'd2, 0);
        chk("sim_start_lvl", 32'(bus0.level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("sim_fwft_head%0d", i), 32'(bus1.pop_data), 32'(i + 1));
            step(0, 1, 8'(i + 3), 1);
            chk($sformatf("sim_std_pd%0d", i), 32'({bus0.pop_valid, bus0.pop_data}),
                32'({1'b1, 8'(i + 1)}));
            chk($sformatf("sim_lvl%0d", i), 32'(bus0.level), 32'd2);
        end
        step(0, 0, 8'h00, 1);
        chk("sim_tail0", 32'(bus0.pop_data), 32'd11);
        step(0, 0, 8'h00, 1);
        chk("sim_tail1", 32'(bus0.pop_data), 32'd12);
        chk("sim_ovf", 32'({bus0.overflow, bus0.underflow}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
